// File: rtl/mul_div_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit.
//   XlenDef      : operand/result width (only 32 supported)
//   BasicData    : XLEN-wide data word
//   MulDivOp     : M-extension operation, funct3 encoding
//   MulDivState  : iteration FSM states
//   helpers      : op classification and two's-complement negate
package mul_div_unit_pkg;

  localparam int XlenDef = 32;

  typedef logic [XlenDef-1:0] BasicData;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } MulDivOp;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } MulDivState;

  // Divide ops all have bit 2 set in the funct3 encoding.
  function automatic logic isDivOp(input MulDivOp o);
    return o[2];
  endfunction

  function automatic logic isSignedDiv(input MulDivOp o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  // REM/REMU return the remainder; DIV/DIVU the quotient.
  function automatic logic isRemOp(input MulDivOp o);
    return o[2] && o[1];
  endfunction

  function automatic BasicData negate(input BasicData v);
    return (~v) + BasicData'(1);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Restoring radix-2 divider datapath for unsigned magnitudes.
//   clk, rstN          : clock, async active-low reset
//   load               : capture dividend/divisor, clear remainder and counter
//   step               : perform one iteration (one quotient bit)
//   dividend, divisor  : unsigned operands sampled on load
//   done               : high during the 32nd step
//   quotient, remainder: current shift-register contents
module div_core
  import mul_div_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rstN,
  input  logic     load,
  input  logic     step,
  input  BasicData dividend,
  input  BasicData divisor,
  output logic     done,
  output BasicData quotient,
  output BasicData remainder
);

  BasicData   remReg;
  BasicData   quoReg;
  BasicData   divisorReg;
  logic [4:0] countReg;

  logic [XlenDef:0] shifted;
  logic [XlenDef:0] diff;

  // Remainder stays below the divisor, so the trial difference never
  // exceeds 32 bits when non-negative; bit 32 is therefore a clean borrow.
  always_comb begin
    shifted = {remReg, quoReg[XlenDef-1]};
    diff    = shifted - {1'b0, divisorReg};
  end

  assign done      = step && (countReg == 5'd31);
  assign quotient  = quoReg;
  assign remainder = remReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      countReg   <= '0;
    end else if (load) begin
      remReg     <= '0;
      quoReg     <= dividend;
      divisorReg <= divisor;
      countReg   <= '0;
    end else if (step) begin
      if (diff[XlenDef]) begin
        remReg <= shifted[XlenDef-1:0];
        quoReg <= {quoReg[XlenDef-2:0], 1'b0};
      end else begin
        remReg <= diff[XlenDef-1:0];
        quoReg <= {quoReg[XlenDef-2:0], 1'b1};
      end
      countReg <= countReg + 5'd1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (Execute stage).
//   clk, rstN   : clock, async active-low reset
//   start       : M-extension op present in Execute (level, held while stalled)
//   op          : MulDivOp (funct3 encoding)
//   rs1, rs2    : bypassed operands
//   clear       : synchronous abort (branch-miss flush)
//   busy        : structure hazard back to the controller (combinational)
//   resultValid : result valid this cycle
//   result      : registered result
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            clear,
  output logic            busy,
  output logic            resultValid,
  output logic [XLEN-1:0] result
);

  MulDivState stateReg;
  MulDivOp    opReg;
  BasicData   rs1Reg, rs2Reg, resultReg;
  logic       negQuoReg, negRemReg;

  MulDivOp  opIn;
  logic     accept, divZero, divOvf, special, signedIn;
  BasicData specialResult, rs1Mag, rs2Mag;
  logic     divLoad, divStep, divDone;
  BasicData quotient, remainder;

  assign opIn   = MulDivOp'(op);
  assign accept = (stateReg == ST_IDLE) && start && !clear;

  // Divide-by-zero and signed overflow are resolved at acceptance and
  // skip the iteration entirely.
  always_comb begin
    signedIn = isSignedDiv(opIn);
    divZero  = (rs2 == '0);
    divOvf   = signedIn && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    special  = divZero || divOvf;
    if (isRemOp(opIn))
      specialResult = divZero ? rs1 : '0;
    else
      specialResult = divZero ? 32'hFFFF_FFFF : 32'h8000_0000;
    rs1Mag = (signedIn && rs1[XLEN-1]) ? negate(rs1) : rs1;
    rs2Mag = (signedIn && rs2[XLEN-1]) ? negate(rs2) : rs2;
  end

  assign divLoad = accept && isDivOp(opIn) && !special;
  assign divStep = (stateReg == ST_DIV) && !clear;

  div_core uDivCore (
    .clk       (clk),
    .rstN      (rstN),
    .load      (divLoad),
    .step      (divStep),
    .dividend  (rs1Mag),
    .divisor   (rs2Mag),
    .done      (divDone),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // 33x33 signed multiply; the extension bit selects signed/unsigned
  // interpretation of each operand. Only the low 64 product bits matter.
  logic        mulSignA, mulSignB;
  logic [63:0] product;
  BasicData    mulResult;

  always_comb begin
    mulSignA  = (opReg == OP_MUL) || (opReg == OP_MULH) || (opReg == OP_MULHSU);
    mulSignB  = (opReg == OP_MUL) || (opReg == OP_MULH);
    product   = $signed({mulSignA && rs1Reg[XLEN-1], rs1Reg}) *
                $signed({mulSignB && rs2Reg[XLEN-1], rs2Reg});
    mulResult = (opReg == OP_MUL) ? product[31:0] : product[63:32];
  end

  BasicData fixResult;
  always_comb begin
    if (isRemOp(opReg))
      fixResult = negRemReg ? negate(remainder) : remainder;
    else
      fixResult = negQuoReg ? negate(quotient) : quotient;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg  <= ST_IDLE;
      opReg     <= OP_MUL;
      rs1Reg    <= '0;
      rs2Reg    <= '0;
      resultReg <= '0;
      negQuoReg <= 1'b0;
      negRemReg <= 1'b0;
    end else if (clear) begin
      stateReg <= ST_IDLE;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (start) begin
            opReg     <= opIn;
            rs1Reg    <= rs1;
            rs2Reg    <= rs2;
            negQuoReg <= signedIn && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            negRemReg <= signedIn && rs1[XLEN-1];
            if (!isDivOp(opIn)) begin
              stateReg <= ST_MUL;
            end else if (special) begin
              resultReg <= specialResult;
              stateReg  <= ST_DONE;
            end else begin
              stateReg <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          resultReg <= mulResult;
          stateReg  <= ST_DONE;
        end
        ST_DIV: begin
          if (divDone) stateReg <= ST_FIX;
        end
        ST_FIX: begin
          resultReg <= fixResult;
          stateReg  <= ST_DONE;
        end
        // DONE always returns to IDLE: a held start is the same instruction.
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

  // Gated by rstN so a held start cannot raise the hazard during reset.
  assign busy = rstN && ((stateReg == ST_MUL) || (stateReg == ST_DIV) ||
                         (stateReg == ST_FIX) || accept);
  assign resultValid = (stateReg == ST_DONE) && !clear;
  assign result      = resultReg;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstN, start, clear;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, resultValid;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .op          (op),
    .rs1         (rs1),
    .rs2         (rs2),
    .clear       (clear),
    .busy        (busy),
    .resultValid (resultValid),
    .result      (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 units after the rising edge; outputs are sampled 1 unit later.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Present an op at cycle T and hold start through DONE (as a stalled
  // pipeline would). busy must be high for T..T+lat-1, result at T+lat.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] exp, input string tag);
    nextCycle();
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    #1;
    for (int c = 0; c < lat; c++) begin
      if (c > 0) begin
        nextCycle();
        #1;
      end
      check($sformatf("%s_busy_T%0d", tag, c), {31'b0, busy}, 32'd1);
      check($sformatf("%s_valid_T%0d", tag, c), {31'b0, resultValid}, 32'd0);
    end
    nextCycle();
    #1;
    check($sformatf("%s_valid", tag), {31'b0, resultValid}, 32'd1);
    check($sformatf("%s_busyDone", tag), {31'b0, busy}, 32'd0);
    check($sformatf("%s_result", tag), result, exp);
    $display("op=%0d rs1=0x%08h rs2=0x%08h result=0x%08h expected=0x%08h", o, a, b, result, exp);
  endtask

  task automatic idleCycle(input string tag);
    nextCycle();
    start = 1'b0;
    #1;
    check($sformatf("%s_idleBusy", tag), {31'b0, busy}, 32'd0);
    check($sformatf("%s_idleValid", tag), {31'b0, resultValid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; start = 1'b0; clear = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;

    // Reset state, including a held start that must not raise busy.
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, resultValid}, 32'd0);
    check("rst_result", result, 32'd0);
    start = 1'b1; op = OP_MUL;
    #1;
    check("rst_busyStart", {31'b0, busy}, 32'd0);
    start = 1'b0;
    nextCycle();
    rstN = 1'b1;
    #1;
    check("rst_state", {29'b0, dut.stateReg}, {29'b0, ST_IDLE});

    // Multiplies
    runOp(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 2, 32'hFFFF_FFFF, "mulh");
    idleCycle("mulh");
    runOp(OP_MUL,    32'h1234_5678, 32'h0000_0010, 2, 32'h2345_6780, "mul");
    idleCycle("mul");
    runOp(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, "mulhsu");
    idleCycle("mulhsu");

    // Normal divides
    runOp(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFD, "div");
    idleCycle("div");
    runOp(OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, "rem");
    idleCycle("rem");
    runOp(OP_DIVU, 32'd100, 32'd7, 34, 32'd14, "divu");
    idleCycle("divu");
    runOp(OP_REMU, 32'd100, 32'd7, 34, 32'd2, "remu");
    idleCycle("remu");
    runOp(OP_DIV,  32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, "divNegDivisor");
    idleCycle("divNegDivisor");
    runOp(OP_REM,  32'd7, 32'hFFFF_FFFE, 34, 32'd1, "remNegDivisor");
    idleCycle("remNegDivisor");

    // Special divides
    runOp(OP_DIVU, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, "divuZero");
    idleCycle("divuZero");
    runOp(OP_REMU, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, "remuZero");
    idleCycle("remuZero");
    runOp(OP_DIV,  32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, "divZero");
    idleCycle("divZero");
    runOp(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "remOvf");
    idleCycle("remOvf");
    runOp(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "divOvf");
    idleCycle("divOvf");

    // Back-to-back with start held through DONE
    runOp(OP_MULH,  32'hFFFF_FFFF, 32'h0000_0002, 2, 32'hFFFF_FFFF, "b2bFirst");
    runOp(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, "b2bSecond");
    idleCycle("b2b");

    // Clear at T+10 of a divide
    nextCycle();
    start = 1'b1; op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7;
    #1;
    check("clr_busyT0", {31'b0, busy}, 32'd1);
    for (int c = 1; c < 10; c++) nextCycle();
    nextCycle();
    clear = 1'b1; start = 1'b0;
    #1;
    check("clr_validT10", {31'b0, resultValid}, 32'd0);
    nextCycle();
    clear = 1'b0;
    #1;
    check("clr_stateT11", {29'b0, dut.stateReg}, {29'b0, ST_IDLE});
    check("clr_busyT11", {31'b0, busy}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      nextCycle();
      #1;
      check($sformatf("clr_noValid_%0d", c), {31'b0, resultValid}, 32'd0);
    end
    $display("clear mid-divide: no result over 40 cycles");

    // clear and start together in IDLE: nothing accepted
    nextCycle();
    start = 1'b1; clear = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5;
    #1;
    check("clrStart_busy", {31'b0, busy}, 32'd0);
    nextCycle();
    start = 1'b0; clear = 1'b0;
    #1;
    check("clrStart_state", {29'b0, dut.stateReg}, {29'b0, ST_IDLE});
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      #1;
      check($sformatf("clrStart_noValid_%0d", c), {31'b0, resultValid}, 32'd0);
    end
    $display("clear+start in IDLE: not accepted");

    // Reset at T+5 of a divide (start still held); result was 0xFFFFFFFE
    nextCycle();
    start = 1'b1; op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7;
    #1;
    check("rstMid_busyT0", {31'b0, busy}, 32'd1);
    for (int c = 1; c < 5; c++) nextCycle();
    nextCycle();
    rstN = 1'b0;
    #1;
    check("rstMid_busy", {31'b0, busy}, 32'd0);
    check("rstMid_valid", {31'b0, resultValid}, 32'd0);
    check("rstMid_result", result, 32'd0);
    nextCycle();
    rstN = 1'b1; start = 1'b0;
    #1;
    check("rstMid_state", {29'b0, dut.stateReg}, {29'b0, ST_IDLE});
    check("rstMid_busyAfter", {31'b0, busy}, 32'd0);
    $display("reset mid-divide: outputs cleared");

    runOp(OP_DIVU, 32'd100, 32'd7, 34, 32'd14, "afterRst");
    idleCycle("afterRst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
